// File: rtl/bcd_time_pkg.sv
// Shared digit limits, state encoding, reset times and BCD increment helpers
// for the time-of-day counter.
package bcd_time_pkg;

  localparam int unsigned SEC_T_MAX = 5;
  localparam int unsigned MIN_T_MAX = 5;
  localparam int unsigned UNIT_MAX  = 9;
  localparam int unsigned HR24_MAX  = 23;
  localparam int unsigned HR12_MAX  = 12;

  typedef enum logic {
    RUN,
    SET
  } state_e;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] u;
  } hours_t;

  typedef struct packed {
    logic [3:0] d;
    logic       carry;
  } digit_step_t;

  typedef struct packed {
    hours_t hr;
    logic   wrap;
  } hour_step_t;

  localparam hours_t RST_HOURS_24 = '{t: 2'd0, u: 4'd0};
  localparam hours_t RST_HOURS_12 = '{t: 2'd1, u: 4'd2};
  localparam logic [2:0] RST_TENS  = 3'd0;
  localparam logic [3:0] RST_UNITS = 4'd0;

  // Out-of-range digits fall back to zero without carrying.
  function automatic digit_step_t digit_inc(input logic [3:0] d, input logic [3:0] max);
    digit_step_t r;
    r.d     = 4'd0;
    r.carry = 1'b0;
    if (d < max) begin
      r.d = d + 4'd1;
    end else if (d == max) begin
      r.carry = 1'b1;
    end
    return r;
  endfunction

  function automatic hours_t to_hours(input logic [5:0] v);
    hours_t h;
    if (v >= 6'd20) begin
      h.t = 2'd2;
      h.u = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      h.t = 2'd1;
      h.u = 4'(v - 6'd10);
    end else begin
      h.t = 2'd0;
      h.u = 4'(v);
    end
    return h;
  endfunction

  // Next hour value; wrap flags the start of a new day. Invalid hours map to
  // the mode's reset hour.
  function automatic hour_step_t hour_inc(input hours_t h, input logic mode_24h);
    hour_step_t r;
    logic [5:0] v;
    logic       u_ok;
    v      = 6'(h.t) * 6'd10 + 6'(h.u);
    u_ok   = (h.u <= 4'(UNIT_MAX));
    r.wrap = 1'b0;
    if (mode_24h) begin
      r.hr = RST_HOURS_24;
      if (u_ok && v < 6'(HR24_MAX)) begin
        r.hr = to_hours(v + 6'd1);
      end else if (u_ok && v == 6'(HR24_MAX)) begin
        r.wrap = 1'b1;
      end
    end else begin
      r.hr = RST_HOURS_12;
      if (u_ok && v >= 6'd1 && v < 6'(HR12_MAX)) begin
        r.hr   = to_hours(v + 6'd1);
        r.wrap = (v == 6'(HR12_MAX - 1));
      end else if (u_ok && v == 6'(HR12_MAX)) begin
        r.hr = to_hours(6'd1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with a history flop; level, rise and fall are all
// registered so they change on the same edge.
module sync_edge_det #(
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;

  // Flops reset to the input's idle level so no event appears on reset exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_LEVEL}};
      hist_q <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[STAGES-1] & hist_q;
    end
  end

  assign level = hist_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter driven by 1 Hz edges, with a button-driven set mode.
// SYNC_STAGES must be at least 2.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter bit          MODE_24H    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       set_n,
  input  logic       adv_min_n,
  input  logic       adv_hour_n,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       tick,
  output logic       day_wrap,
  output logic       setting
);

  localparam hours_t RST_HOURS = MODE_24H ? RST_HOURS_24 : RST_HOURS_12;

  logic sec_ev, min_ev, hour_ev, set_lvl;
  logic unused_sec_level, unused_sec_fall;
  logic unused_set_rise, unused_set_fall;
  logic unused_min_level, unused_min_rise;
  logic unused_hour_level, unused_hour_rise;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sec (
    .clk  (clk_50MHz),
    .rst  (rst),
    .din  (clk_1Hz),
    .level(unused_sec_level),
    .rise (sec_ev),
    .fall (unused_sec_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_set (
    .clk  (clk_50MHz),
    .rst  (rst),
    .din  (set_n),
    .level(set_lvl),
    .rise (unused_set_rise),
    .fall (unused_set_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_min (
    .clk  (clk_50MHz),
    .rst  (rst),
    .din  (adv_min_n),
    .level(unused_min_level),
    .rise (unused_min_rise),
    .fall (min_ev)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_hour (
    .clk  (clk_50MHz),
    .rst  (rst),
    .din  (adv_hour_n),
    .level(unused_hour_level),
    .rise (unused_hour_rise),
    .fall (hour_ev)
  );

  state_e     state_q;
  hours_t     hr_q;
  logic [2:0] min_t_q, sec_t_q;
  logic [3:0] min_u_q, sec_u_q;
  logic       tick_q, wrap_q;

  digit_step_t su_n, st_n, mu_n, mt_n;
  hour_step_t  hr_n;

  always_comb begin
    su_n = digit_inc(sec_u_q, 4'(UNIT_MAX));
    st_n = digit_inc({1'b0, sec_t_q}, 4'(SEC_T_MAX));
    mu_n = digit_inc(min_u_q, 4'(UNIT_MAX));
    mt_n = digit_inc({1'b0, min_t_q}, 4'(MIN_T_MAX));
    hr_n = hour_inc(hr_q, MODE_24H);
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= RUN;
      hr_q    <= RST_HOURS;
      min_t_q <= RST_TENS;
      min_u_q <= RST_UNITS;
      sec_t_q <= RST_TENS;
      sec_u_q <= RST_UNITS;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          // Entering set mode takes priority over a coincident second tick.
          if (!set_lvl) begin
            state_q <= SET;
            sec_t_q <= RST_TENS;
            sec_u_q <= RST_UNITS;
          end else if (sec_ev) begin
            tick_q  <= 1'b1;
            sec_u_q <= su_n.d;
            if (su_n.carry) begin
              sec_t_q <= st_n.d[2:0];
              if (st_n.carry) begin
                min_u_q <= mu_n.d;
                if (mu_n.carry) begin
                  min_t_q <= mt_n.d[2:0];
                  if (mt_n.carry) begin
                    hr_q   <= hr_n.hr;
                    wrap_q <= hr_n.wrap;
                  end
                end
              end
            end
          end
        end
        SET: begin
          sec_t_q <= RST_TENS;
          sec_u_q <= RST_UNITS;
          if (set_lvl) begin
            state_q <= RUN;
          end else begin
            if (min_ev) begin
              min_u_q <= mu_n.d;
              if (mu_n.carry) begin
                min_t_q <= mt_n.d[2:0];
              end
            end
            if (hour_ev) begin
              hr_q <= hr_n.hr;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign hr_t     = hr_q.t;
  assign hr_u     = hr_q.u;
  assign min_t    = min_t_q;
  assign min_u    = min_u_q;
  assign sec_t    = sec_t_q;
  assign sec_u    = sec_u_q;
  assign tick     = tick_q;
  assign day_wrap = wrap_q;
  assign setting  = (state_q == SET);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: a 24-hour and a 12-hour counter share stimulus; expected
// times are queued when a second pulse is driven and compared on each tick.
module tb_bcd_time_counter;

  localparam int unsigned SyncStages = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_1hz = 1'b0;
  logic set_n = 1'b1;
  logic adv_min_n = 1'b1;
  logic adv_hour_n = 1'b1;

  logic [1:0] hr_t, hr_t12;
  logic [3:0] hr_u, hr_u12;
  logic [2:0] min_t, min_t12;
  logic [3:0] min_u, min_u12;
  logic [2:0] sec_t, sec_t12;
  logic [3:0] sec_u, sec_u12;
  logic       tick, tick12, day_wrap, day_wrap12, setting, setting12;

  bcd_time_counter #(.MODE_24H(1'b1), .SYNC_STAGES(SyncStages)) dut (
    .clk_50MHz(clk), .rst(rst), .clk_1Hz(clk_1hz), .set_n(set_n),
    .adv_min_n(adv_min_n), .adv_hour_n(adv_hour_n),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .tick(tick), .day_wrap(day_wrap), .setting(setting)
  );

  bcd_time_counter #(.MODE_24H(1'b0), .SYNC_STAGES(SyncStages)) dut12 (
    .clk_50MHz(clk), .rst(rst), .clk_1Hz(clk_1hz), .set_n(set_n),
    .adv_min_n(adv_min_n), .adv_hour_n(adv_hour_n),
    .hr_t(hr_t12), .hr_u(hr_u12), .min_t(min_t12), .min_u(min_u12),
    .sec_t(sec_t12), .sec_u(sec_u12), .tick(tick12), .day_wrap(day_wrap12),
    .setting(setting12)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [23:0] t24;
    logic [23:0] t12;
    logic        w24;
    logic        w12;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   tick_count = 0;
  logic prev_tick = 1'b0;

  // Reference model: plain integers, hours kept separately per mode.
  int   h24 = 0, h12 = 12, m = 0, s = 0;
  logic exp_set = 1'b0;
  logic w24, w12;

  logic [23:0] got24, got12;
  assign got24 = {2'b0, hr_t, hr_u, 1'b0, min_t, min_u, 1'b0, sec_t, sec_u};
  assign got12 = {2'b0, hr_t12, hr_u12, 1'b0, min_t12, min_u12, 1'b0, sec_t12, sec_u12};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] bcd_time(input int h, input int mi, input int se);
    logic [23:0] r;
    r = {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_time24"}, 32'(got24), 32'(bcd_time(h24, m, s)));
    check_eq({tag, "_time12"}, 32'(got12), 32'(bcd_time(h12, m, s)));
    check_eq({tag, "_setting24"}, 32'(setting), 32'(exp_set));
    check_eq({tag, "_setting12"}, 32'(setting12), 32'(exp_set));
  endtask

  task automatic hour_adv();
    h24 = (h24 + 1) % 24;
    h12 = (h12 == 12) ? 1 : h12 + 1;
  endtask

  task automatic model_second();
    w24 = 1'b0;
    w12 = 1'b0;
    s++;
    if (s == 60) begin
      s = 0;
      m++;
      if (m == 60) begin
        m = 0;
        w12 = (h12 == 11);
        hour_adv();
        w24 = (h24 == 0);
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo, input bit expect_tick);
    exp_t e;
    @(negedge clk);
    clk_1hz  = 1'b1;
    rise_cyc = cyc;
    if (expect_tick) begin
      model_second();
      e.t24 = bcd_time(h24, m, s);
      e.t12 = bcd_time(h12, m, s);
      e.w24 = w24;
      e.w12 = w12;
      exp_q.push_back(e);
    end
    repeat (hi) @(negedge clk);
    clk_1hz = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic press(input bit do_min, input bit do_hr, input int hold);
    @(negedge clk);
    if (do_min) adv_min_n = 1'b0;
    if (do_hr) adv_hour_n = 1'b0;
    if (exp_set) begin
      if (do_min) m = (m + 1) % 60;
      if (do_hr) hour_adv();
    end
    repeat (hold) @(negedge clk);
    adv_min_n  = 1'b1;
    adv_hour_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_mode(input bit on);
    @(negedge clk);
    set_n = ~on;
    repeat (SyncStages + 4) @(negedge clk);
    exp_set = on;
    if (on) s = 0;
  endtask

  // Tick monitor: pops one expected record per observed tick.
  always @(negedge clk) begin
    if (tick) begin
      tick_count++;
      check_eq("tick_width", 32'(prev_tick), 32'd0);
      check_eq("tick_latency", 32'(cyc - rise_cyc), 32'(SyncStages + 2));
      check_eq("tick12_align", 32'(tick12), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("tick_unexpected", 32'(tick), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("tick_time24", 32'(got24), 32'(mon_e.t24));
        check_eq("tick_time12", 32'(got12), 32'(mon_e.t12));
        check_eq("tick_wrap24", 32'(day_wrap), 32'(mon_e.w24));
        check_eq("tick_wrap12", 32'(day_wrap12), 32'(mon_e.w12));
      end
    end else if (tick12) begin
      check_eq("tick12_alone", 32'(tick12), 32'd0);
    end
    if (day_wrap && !tick) check_eq("wrap24_no_tick", 32'(day_wrap), 32'd0);
    if (day_wrap12 && !tick12) check_eq("wrap12_no_tick", 32'(day_wrap12), 32'd0);
    prev_tick = tick;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_state("reset");
    check_eq("reset_tick", 32'(tick | tick12), 32'd0);
    check_eq("reset_wrap", 32'(day_wrap | day_wrap12), 32'd0);
    repeat (8) @(negedge clk);
    check_state("post_reset");

    tick_count = 0;
    for (int i = 0; i < 10; i++) pulse(100, 100, 1'b1);
    check_eq("ten_ticks", 32'(tick_count), 32'd10);
    check_state("after_10s");

    for (int i = 0; i < 27; i++) pulse(10, 10, 1'b1);
    check_state("at_37s");
    set_mode(1'b1);
    check_state("enter_set");
    for (int i = 0; i < 3; i++) pulse(10, 10, 1'b0);
    check_state("set_ignores_sec");

    for (int i = 0; i < 60; i++) begin
      press(1'b1, 1'b0, 6);
      if (i == 58) check_state("min_59");
    end
    check_state("min_wrap");
    for (int i = 0; i < 24; i++) press(1'b0, 1'b1, 6);
    check_state("hour_24_presses");

    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 6);
    for (int i = 0; i < 59; i++) press(1'b1, 1'b0, 6);
    check_state("at_0559");
    press(1'b1, 1'b1, 6);
    check_state("both_adv");
    press(1'b1, 1'b0, 1000);
    check_state("held_min");

    for (int i = 0; i < 17; i++) press(1'b0, 1'b1, 6);
    for (int i = 0; i < 58; i++) press(1'b1, 1'b0, 6);
    check_state("at_2359");
    set_mode(1'b0);
    check_state("exit_set");
    for (int i = 0; i < 60; i++) pulse(10, 10, 1'b1);
    check_state("day_wrap");

    set_mode(1'b1);
    for (int i = 0; i < 59; i++) press(1'b1, 1'b0, 6);
    set_mode(1'b0);
    for (int i = 0; i < 60; i++) pulse(10, 10, 1'b1);
    check_state("at_0100");

    set_mode(1'b1);
    for (int i = 0; i < 13; i++) press(1'b0, 1'b1, 6);
    for (int i = 0; i < 22; i++) press(1'b1, 1'b0, 6);
    check_state("at_1422");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    h24 = 0; h12 = 12; m = 0; s = 0; exp_set = 1'b0;
    check_state("rst_in_set");
    repeat (SyncStages + 4) @(negedge clk);
    exp_set = 1'b1;
    check_state("reenter_set");

    set_mode(1'b0);
    for (int i = 0; i < 3; i++) pulse(10, 10, 1'b1);
    check_state("at_03s");
    @(negedge clk);
    set_n    = 1'b0;
    clk_1hz  = 1'b1;
    rise_cyc = cyc;
    repeat (10) @(negedge clk);
    clk_1hz = 1'b0;
    repeat (10) @(negedge clk);
    exp_set = 1'b1;
    s = 0;
    check_state("set_beats_tick");

    set_mode(1'b0);
    repeat (10) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
